apb_cmd_bridge: RTL

APB master bridge that sits between the CPU command port and the APB peripheral bus. The CPU issues a held-level command (`APBMASTERENABLE`, `addr`, `data`, `CPUSEL`). The bridge turns each command into one APB SETUP/ACCESS transfer to the selected peripheral. It then returns a one-cycle `CPUPREADY` pulse, with read data and error status. It is the responder for the CPU's APB command interface, and it owns the APB wait-state, timeout and peripheral soft-reset handling.

---
 rtl/apb_bridge_pkg.sv | 37 +++
 rtl/apb_sel_decode.sv | 21 ++
 rtl/apb_cmd_bridge.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared types and command-code decoding for the CPU-to-APB command bridge.
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_RELEASE
  } apb_state_t;

  localparam logic [7:0] SEL_WR_P0 = 8'h01;
  localparam logic [7:0] SEL_WR_P1 = 8'h02;
  localparam logic [7:0] SEL_RD_P0 = 8'h04;
  localparam logic [7:0] SEL_RD_P1 = 8'h05;

  typedef struct packed {
    logic       valid;
    logic       write;
    logic [1:0] psel;
  } sel_dec_t;

  // Unknown codes decode to all-zero, so psel stays idle for them.
  function automatic sel_dec_t decode_sel(input logic [7:0] code);
    sel_dec_t d;
    d = '0;
    case (code)
      SEL_WR_P0: d = '{valid: 1'b1, write: 1'b1, psel: 2'b01};
      SEL_WR_P1: d = '{valid: 1'b1, write: 1'b1, psel: 2'b10};
      SEL_RD_P0: d = '{valid: 1'b1, write: 1'b0, psel: 2'b01};
      SEL_RD_P1: d = '{valid: 1'b1, write: 1'b0, psel: 2'b10};
      default:   d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/apb_sel_decode.sv
// Combinational decode of the CPU command code into valid / write / one-hot select.
module apb_sel_decode
  import apb_bridge_pkg::*;
(
  input  logic [7:0] cpusel,
  output logic       valid,
  output logic       write,
  output logic [1:0] psel
);

  sel_dec_t dec;

  always_comb begin
    dec = decode_sel(cpusel);
  end

  assign valid = dec.valid;
  assign write = dec.write;
  assign psel  = dec.psel;

endmodule

// File: rtl/apb_cmd_bridge.sv
// CPU command port to APB master: one SETUP/ACCESS transfer per command,
// with wait-state timeout and a one-cycle completion pulse back to the CPU.
module apb_cmd_bridge
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 21,
  parameter int TIMEOUT = 16
) (
  input  logic              CCLK,
  input  logic              CPURESET,
  input  logic              CPUPERPHRESET,
  input  logic              APBMASTERENABLE,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic [7:0]        CPUSEL,
  output logic              CPUPREADY,
  output logic              CPUERR,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb_state_t        state_reg, state_next;
  logic [1:0]        psel_cap_reg, psel_cap_next;
  logic              write_reg, write_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic              err_reg, err_next;
  logic [1:0]        psel_reg, psel_next;
  logic              penable_reg, penable_next;
  logic              cpupready_reg, cpupready_next;
  logic              cpuerr_reg, cpuerr_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;

  logic       dec_valid;
  logic       dec_write;
  logic [1:0] dec_psel;

  apb_sel_decode u_sel_decode (
    .cpusel (CPUSEL),
    .valid  (dec_valid),
    .write  (dec_write),
    .psel   (dec_psel)
  );

  always_comb begin
    state_next    = state_reg;
    psel_cap_next = psel_cap_reg;
    write_next    = write_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    wait_cnt_next = wait_cnt_reg;
    err_next      = err_reg;
    rdata_next    = rdata_reg;

    case (state_reg)
      ST_IDLE: begin
        if (APBMASTERENABLE) begin
          if (dec_valid) begin
            psel_cap_next = dec_psel;
            write_next    = dec_write;
            addr_next     = addr;
            wdata_next    = data;
            wait_cnt_next = '0;
            err_next      = 1'b0;
            state_next    = ST_SETUP;
          end else begin
            err_next   = 1'b1;
            state_next = ST_DONE;
          end
        end
      end
      ST_SETUP: begin
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A ready slave wins over the timeout on the same edge.
        if (PREADY) begin
          err_next = PSLVERR;
          if (!write_reg && !PSLVERR) begin
            rdata_next = PRDATA;
          end
          state_next = ST_DONE;
        end else begin
          wait_cnt_next = wait_cnt_reg + CNT_W'(1);
          if (wait_cnt_reg == CNT_LAST) begin
            err_next   = 1'b1;
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!APBMASTERENABLE) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    psel_next      = ((state_next == ST_SETUP) || (state_next == ST_ACCESS)) ? psel_cap_next : 2'b00;
    penable_next   = (state_next == ST_ACCESS);
    cpupready_next = (state_next == ST_DONE);
    cpuerr_next    = (state_next == ST_DONE) && err_next;
  end

  always_ff @(posedge CCLK) begin
    if (CPURESET || CPUPERPHRESET) begin
      state_reg     <= ST_IDLE;
      psel_cap_reg  <= '0;
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wait_cnt_reg  <= '0;
      err_reg       <= 1'b0;
      psel_reg      <= '0;
      penable_reg   <= 1'b0;
      cpupready_reg <= 1'b0;
      cpuerr_reg    <= 1'b0;
      rdata_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      psel_cap_reg  <= psel_cap_next;
      write_reg     <= write_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      wait_cnt_reg  <= wait_cnt_next;
      err_reg       <= err_next;
      psel_reg      <= psel_next;
      penable_reg   <= penable_next;
      cpupready_reg <= cpupready_next;
      cpuerr_reg    <= cpuerr_next;
      rdata_reg     <= rdata_next;
    end
  end

  assign CPUPREADY = cpupready_reg;
  assign CPUERR    = cpuerr_reg;
  assign RDATA     = rdata_reg;
  assign PSEL      = psel_reg;
  assign PENABLE   = penable_reg;
  assign PWRITE    = write_reg;
  assign PADDR     = addr_reg;
  assign PWDATA    = wdata_reg;

endmodule
